// File: rtl/rsc_turbo_encoder.sv
// rsc_turbo_encoder: LTE RSC constituent encoder (fb 1+D2+D3, fwd 1+D+D3)
// producing systematic/parity bits and +/-MAG BPSK LLRs for FPTD sections.
// Optional build macro FPTD_TERM_EN: adds three trellis-termination steps.
// Ports: Clock, nReset (async, low), nClear (sync, low), Enable (hold when low),
//   Start; in_valid/in_bit/in_ready input handshake; out_valid/out_ready
//   output handshake carrying b1_ideal, b2, ba1, ba2, tail, last; busy, done.
module rsc_turbo_encoder #(
  parameter int M   = 6,
  parameter int K   = 40,
  parameter int MAG = 8
) (
  input  logic                Clock,
  input  logic                nReset,
  input  logic                nClear,
  input  logic                Enable,
  input  logic                Start,
  input  logic                in_valid,
  input  logic                in_bit,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                b1_ideal,
  output logic                b2,
  output logic signed [M-1:0] ba1,
  output logic signed [M-1:0] ba2,
  output logic                tail,
  output logic                last,
  output logic                busy,
  output logic                done
);

  localparam int CW = $clog2(K + 1);
  localparam logic signed [M-1:0] POS = M'(MAG);
  localparam logic signed [M-1:0] NEG = -POS;

`ifdef FPTD_TERM_EN
  typedef enum logic [1:0] {IDLE, DATA, TERM, DRAIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA, DRAIN} state_t;
`endif

  state_t          st;
  logic [2:0]      trellis;
  logic [CW-1:0]   cnt;
  logic            slot_free;
  logic            accept;
  logic            load;
  logic            din;
  logic            fb;
  logic            par;
  logic            data_last;
  logic            last_step;
  logic            is_tail;

  function automatic logic signed [M-1:0] llr(input logic b);
    return b ? NEG : POS;
  endfunction

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = Enable && (st == DATA) && slot_free;
  assign accept    = in_valid && in_ready;
  assign data_last = (cnt == CW'(K - 1));
  assign busy      = (st != IDLE);

`ifdef FPTD_TERM_EN
  logic [1:0] tcnt;
  logic       load_tail;
  assign is_tail   = (st == TERM);
  assign load_tail = Enable && is_tail && slot_free;
  assign load      = accept || load_tail;
  assign last_step = load_tail && (tcnt == 2'd2);
  // tail input cancels the feedback so the register flushes to zero
  assign din       = is_tail ? (trellis[1] ^ trellis[2]) : in_bit;
`else
  assign is_tail   = 1'b0;
  assign load      = accept;
  assign last_step = accept && data_last;
  assign din       = in_bit;
`endif

  // trellis[0] = s1 (newest), trellis[2] = s3
  assign fb  = din ^ trellis[1] ^ trellis[2];
  assign par = fb ^ trellis[0] ^ trellis[2];

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      st        <= IDLE;
      trellis   <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      b1_ideal  <= 1'b0;
      b2        <= 1'b0;
      ba1       <= '0;
      ba2       <= '0;
      tail      <= 1'b0;
      last      <= 1'b0;
      done      <= 1'b0;
`ifdef FPTD_TERM_EN
      tcnt      <= '0;
`endif
    end else if (!nClear) begin
      st        <= IDLE;
      trellis   <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      b1_ideal  <= 1'b0;
      b2        <= 1'b0;
      ba1       <= '0;
      ba2       <= '0;
      tail      <= 1'b0;
      last      <= 1'b0;
      done      <= 1'b0;
`ifdef FPTD_TERM_EN
      tcnt      <= '0;
`endif
    end else if (Enable) begin
      done <= 1'b0;
      if (load) begin
        out_valid <= 1'b1;
        b1_ideal  <= din;
        b2        <= par;
        ba1       <= llr(din);
        ba2       <= llr(par);
        tail      <= is_tail;
        last      <= last_step;
        trellis   <= {trellis[1:0], fb};
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      unique case (st)
        IDLE: begin
          if (Start) begin
            st      <= DATA;
            trellis <= '0;
            cnt     <= '0;
          end
        end
        DATA: begin
          if (accept) begin
            cnt <= cnt + 1'b1;
            if (data_last) begin
`ifdef FPTD_TERM_EN
              st   <= TERM;
              tcnt <= '0;
`else
              st   <= DRAIN;
`endif
            end
          end
        end
`ifdef FPTD_TERM_EN
        TERM: begin
          if (load_tail) begin
            tcnt <= tcnt + 2'd1;
            if (tcnt == 2'd2) st <= DRAIN;
          end
        end
`endif
        DRAIN: begin
          if (out_valid && out_ready) begin
            st   <= IDLE;
            done <= 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsc_turbo_encoder.sv
// tb_rsc_turbo_encoder: directed bench for rsc_turbo_encoder (K=40 and K=1
// instances); expected steps come from hand constants and a behavioural model.
module tb_rsc_turbo_encoder;

  localparam int KA = 40;
`ifdef FPTD_TERM_EN
  localparam int NT = 3;
`else
  localparam int NT = 0;
`endif
  localparam logic [5:0] P8 = 6'h08;
  localparam logic [5:0] N8 = 6'h38;

  typedef struct packed {
    logic       b1;
    logic       b2;
    logic [5:0] l1;
    logic [5:0] l2;
    logic       tl;
    logic       ls;
  } step_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, nclr, en;
  logic a_start, a_iv, a_ib, a_ir, a_ov, a_or;
  logic a_b1, a_b2, a_tail, a_last, a_busy, a_done;
  logic signed [5:0] a_ba1, a_ba2;
  logic b_start, b_iv, b_ib, b_ir, b_ov, b_or;
  logic b_b1, b_b2, b_tail, b_last, b_busy, b_done;
  logic signed [5:0] b_ba1, b_ba2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int a_dn = 0;
  int b_dn = 0;
  step_t qa[$];
  step_t qb[$];
  int qt[$];

  rsc_turbo_encoder #(.M(6), .K(KA), .MAG(8)) dut_a (
    .Clock(clk), .nReset(rst_n), .nClear(nclr), .Enable(en),
    .Start(a_start), .in_valid(a_iv), .in_bit(a_ib), .in_ready(a_ir),
    .out_valid(a_ov), .out_ready(a_or), .b1_ideal(a_b1), .b2(a_b2),
    .ba1(a_ba1), .ba2(a_ba2), .tail(a_tail), .last(a_last),
    .busy(a_busy), .done(a_done)
  );

  rsc_turbo_encoder #(.M(6), .K(1), .MAG(8)) dut_b (
    .Clock(clk), .nReset(rst_n), .nClear(nclr), .Enable(en),
    .Start(b_start), .in_valid(b_iv), .in_bit(b_ib), .in_ready(b_ir),
    .out_valid(b_ov), .out_ready(b_or), .b1_ideal(b_b1), .b2(b_b2),
    .ba1(b_ba1), .ba2(b_ba2), .tail(b_tail), .last(b_last),
    .busy(b_busy), .done(b_done)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (a_ov && a_or) begin
      qa.push_back({a_b1, a_b2, a_ba1, a_ba2, a_tail, a_last});
      qt.push_back(cyc);
    end
    if (b_ov && b_or) qb.push_back({b_b1, b_b2, b_ba1, b_ba2, b_tail, b_last});
    if (a_done) a_dn <= a_dn + 1;
    if (b_done) b_dn <= b_dn + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic step_t mk(input logic b1, input logic b2,
                               input logic tl, input logic ls);
    mk = {b1, b2, (b1 ? N8 : P8), (b2 ? N8 : P8), tl, ls};
  endfunction

  // Run one K=40 frame on dut_a, optionally stalling out_ready, then
  // compare every consumed step against the encoder equations.
  task automatic run_a(input logic [39:0] data, input int st_at,
                       input int st_len, input bit contig);
    int i, sc, n, dn0, lim;
    logic acc, stall, seen;
    logic [15:0] snap;
    logic [2:0] ms;
    logic f, z, x;
    step_t ex[$];
    qa.delete();
    qt.delete();
    dn0 = a_dn;
    a_or = 1'b1;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    i = 0; sc = 0; lim = 0;
    while (i < KA && lim < 500) begin
      stall = (st_len > 0) && (i >= st_at) && (sc < st_len);
      a_or = !stall;
      a_iv = 1'b1;
      a_ib = data[i];
      @(negedge clk);
      if (stall) begin
        chk($sformatf("bp_ready_c%0d", sc), {30'd0, a_ir, a_ov}, 32'd1);
        if (sc == 0) snap = {a_b1, a_b2, a_ba1, a_ba2, a_tail, a_last};
        else chk($sformatf("bp_hold_c%0d", sc),
                 {16'd0, a_b1, a_b2, a_ba1, a_ba2, a_tail, a_last},
                 {16'd0, snap});
        sc++;
      end
      acc = a_iv && a_ir;
      @(posedge clk); #1;
      if (acc) i++;
      lim++;
    end
    chk("a_bits_accepted", i, KA);
    a_iv = 1'b0;
    a_or = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(posedge clk); #1;
      if (a_dn != dn0) seen = 1'b1;
    end
    chk("a_done_seen", {31'd0, seen}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("a_done_once", a_dn - dn0, 1);
    chk("a_idle_after", {31'd0, a_busy}, 32'd0);
    ms = 3'b000;
    for (int j = 0; j < KA; j++) begin
      f = data[j] ^ ms[1] ^ ms[2];
      z = f ^ ms[0] ^ ms[2];
      ex.push_back(mk(data[j], z, 1'b0, (NT == 0) && (j == KA - 1)));
      ms = {ms[1:0], f};
    end
    for (int j = 0; j < NT; j++) begin
      x = ms[1] ^ ms[2];
      z = ms[0] ^ ms[2];
      ex.push_back(mk(x, z, 1'b1, j == NT - 1));
      ms = {ms[1:0], 1'b0};
    end
    n = ex.size();
    chk("a_nsteps", qa.size(), n);
    for (int j = 0; j < n; j++) begin
      if (j < qa.size())
        chk($sformatf("a_step%0d", j), {16'd0, qa[j]}, {16'd0, ex[j]});
    end
    if (contig && qt.size() == n)
      chk("a_contiguous", qt[n-1] - qt[0], n - 1);
  endtask

  initial begin
    step_t eb[$];
    logic seen;
    int dn0;
    rst_n = 1'b0; nclr = 1'b1; en = 1'b1;
    a_start = 0; a_iv = 0; a_ib = 0; a_or = 1;
    b_start = 0; b_iv = 0; b_ib = 0; b_or = 1;
    #12;
    chk("rst_a_outs",
        {16'd0, a_ov, a_b1, a_b2, a_tail, a_last, a_busy, a_done, a_ir,
         a_ba1, a_ba2}, 32'd0);
    chk("rst_b_outs",
        {24'd0, b_ov, b_b1, b_b2, b_tail, b_last, b_busy, b_done, b_ir},
        32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Enable low: Start must not take effect
    en = 1'b0;
    a_start = 1'b1;
    @(posedge clk); #1;
    chk("en_hold_busy", {31'd0, a_busy}, 32'd0);
    a_start = 1'b0;
    en = 1'b1;
    @(posedge clk); #1;
    chk("en_start_dropped", {31'd0, a_busy}, 32'd0);

    // impulse
    run_a(40'h1, 0, 0, 1'b1);
    if (qa.size() >= 5) begin
      chk("imp_b1", {qa[0].b1, qa[1].b1, qa[2].b1, qa[3].b1, qa[4].b1}, 5'b10000);
      chk("imp_b2", {qa[0].b2, qa[1].b2, qa[2].b2, qa[3].b2, qa[4].b2}, 5'b11110);
      chk("imp_ba1", {qa[0].l1, qa[1].l1, qa[2].l1, qa[3].l1, qa[4].l1},
          {N8, P8, P8, P8, P8});
    end

    // all-zero frame
    run_a(40'h0, 0, 0, 1'b1);
    if (qa.size() == KA + NT) begin
      chk("zero_last_step", {31'd0, qa[KA+NT-1].ls}, 32'd1);
      chk("zero_llr", {20'd0, qa[KA+NT-1].l1, qa[KA+NT-1].l2}, {20'd0, P8, P8});
    end

    // backpressure mid-frame
    run_a(40'hA53C960FE1, 17, 5, 1'b0);

    // synchronous clear mid-frame
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    a_iv = 1'b1; a_ib = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("clr_pre", {30'd0, a_busy, a_ov}, 32'd3);
    nclr = 1'b0;
    @(posedge clk); #1;
    chk("clr_post", {16'd0, a_busy, a_ov, a_b1, a_b2, a_ir, 5'd0, a_ba1},
        32'd0);
    nclr = 1'b1;
    a_iv = 1'b0;
    @(posedge clk); #1;

    // asynchronous reset mid-frame
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    a_iv = 1'b1; a_ib = 1'b1;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_outs",
        {16'd0, a_ov, a_b1, a_b2, a_tail, a_last, a_busy, a_done, a_ir,
         a_ba1, a_ba2}, 32'd0);
    a_iv = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_a(40'h1, 0, 0, 1'b1);

    // K=1 frame, in=1
    qb.delete();
    dn0 = b_dn;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    b_iv = 1'b1; b_ib = 1'b1;
    @(posedge clk); #1;
    b_iv = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(posedge clk); #1;
      if (b_dn != dn0) seen = 1'b1;
    end
    chk("b_done_seen", {31'd0, seen}, 32'd1);
`ifdef FPTD_TERM_EN
    eb.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0));
    eb.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0));
    eb.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0));
    eb.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1));
    chk("b_final_state", {29'd0, dut_b.trellis}, 32'd0);
`else
    eb.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1));
`endif
    chk("b_nsteps", qb.size(), eb.size());
    for (int j = 0; j < eb.size(); j++) begin
      if (j < qb.size())
        chk($sformatf("b_step%0d", j), {16'd0, qb[j]}, {16'd0, eb[j]});
    end

    // in_valid in IDLE is ignored
    b_iv = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("b_idle_ignore", {29'd0, b_ov, b_busy, b_ir}, 32'd0);
    b_iv = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
